// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one fixed-latency memory port between icache refill and core data.
module mem_port_arbiter #(
    parameter int DATABITWIDTH       = 16,
    parameter int ADDRESSWIDTH       = 10,
    parameter int LINESIZE           = 8,
    parameter int EXT_MEMORY_LATENCY = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clk_en,
    input  logic                    i_req,
    input  logic [ADDRESSWIDTH-1:0] i_addr,
    output logic                    i_ack,
    output logic                    i_rvalid,
    output logic [DATABITWIDTH-1:0] i_rdata,
    output logic                    i_last,
    input  logic                    d_req,
    input  logic                    d_we,
    input  logic [ADDRESSWIDTH-1:0] d_addr,
    input  logic [DATABITWIDTH-1:0] d_wdata,
    output logic                    d_ack,
    output logic                    d_rvalid,
    output logic [DATABITWIDTH-1:0] d_rdata,
    output logic [ADDRESSWIDTH-1:0] mem_addr,
    output logic                    mem_we,
    output logic [DATABITWIDTH-1:0] mem_wdata,
    input  logic [DATABITWIDTH-1:0] mem_rdata,
    output logic                    ic_invalidate,
    output logic [ADDRESSWIDTH-1:0] ic_invalidate_address
);

    localparam int OFFS = $clog2(LINESIZE);
    localparam int CW   = (EXT_MEMORY_LATENCY > 1) ? $clog2(EXT_MEMORY_LATENCY) : 1;
    localparam logic [CW-1:0]   LAT_LAST  = CW'(EXT_MEMORY_LATENCY - 1);
    localparam logic [OFFS-1:0] WORD_LAST = OFFS'(LINESIZE - 1);

    typedef enum logic [1:0] {IDLE, I_BURST, D_ACCESS} state_t;

    state_t                  state_q, state_d;
    logic [CW-1:0]           lat_cnt_q, lat_cnt_d;
    logic [OFFS-1:0]         word_q, word_d;
    logic                    last_grant_q, last_grant_d;   // 1 = I-port won last
    logic [ADDRESSWIDTH-1:0] mem_addr_q, mem_addr_d;
    logic                    mem_we_q, mem_we_d;
    logic [DATABITWIDTH-1:0] mem_wdata_q, mem_wdata_d;
    logic                    inv_q, inv_d;
    logic [ADDRESSWIDTH-1:0] inv_addr_q, inv_addr_d;

    logic win_last;
    logic pick_i;
    logic pick_d;
    logic unused_i_addr_offs;

    // Line offset bits of the refill address are replaced by the word pointer.
    assign unused_i_addr_offs = ^i_addr[OFFS-1:0];

    assign win_last = (lat_cnt_q == LAT_LAST);
    assign pick_i   = i_req & (~d_req | ~last_grant_q);
    assign pick_d   = d_req & ~pick_i;

    always_comb begin
        state_d      = state_q;
        lat_cnt_d    = lat_cnt_q;
        word_d       = word_q;
        last_grant_d = last_grant_q;
        mem_addr_d   = mem_addr_q;
        mem_we_d     = mem_we_q;
        mem_wdata_d  = mem_wdata_q;
        inv_d        = 1'b0;
        inv_addr_d   = inv_addr_q;
        i_ack        = 1'b0;
        i_rvalid     = 1'b0;
        i_rdata      = '0;
        i_last       = 1'b0;
        d_ack        = 1'b0;
        d_rvalid     = 1'b0;
        d_rdata      = '0;

        case (state_q)
            IDLE: begin
                i_ack = clk_en & ~rst & pick_i;
                d_ack = clk_en & ~rst & pick_d;
                if (pick_i) begin
                    state_d      = I_BURST;
                    lat_cnt_d    = '0;
                    word_d       = '0;
                    last_grant_d = 1'b1;
                    mem_addr_d   = {i_addr[ADDRESSWIDTH-1:OFFS], {OFFS{1'b0}}};
                    mem_we_d     = 1'b0;
                end else if (pick_d) begin
                    state_d      = D_ACCESS;
                    lat_cnt_d    = '0;
                    last_grant_d = 1'b0;
                    mem_addr_d   = d_addr;
                    mem_we_d     = d_we;
                    mem_wdata_d  = d_wdata;
                    inv_d        = d_we;
                    if (d_we) begin
                        inv_addr_d = d_addr;
                    end
                end
            end

            I_BURST: begin
                i_rvalid = clk_en & win_last;
                i_last   = clk_en & win_last & (word_q == WORD_LAST);
                if (clk_en & win_last) begin
                    i_rdata = mem_rdata;
                end
                if (win_last) begin
                    lat_cnt_d = '0;
                    if (word_q == WORD_LAST) begin
                        state_d = IDLE;
                        word_d  = '0;
                    end else begin
                        word_d     = word_q + OFFS'(1);
                        mem_addr_d = {mem_addr_q[ADDRESSWIDTH-1:OFFS], word_q + OFFS'(1)};
                    end
                end else begin
                    lat_cnt_d = lat_cnt_q + CW'(1);
                end
            end

            D_ACCESS: begin
                d_rvalid = clk_en & win_last;
                if (clk_en & win_last & ~mem_we_q) begin
                    d_rdata = mem_rdata;
                end
                if (win_last) begin
                    state_d   = IDLE;
                    lat_cnt_d = '0;
                    mem_we_d  = 1'b0;
                end else begin
                    lat_cnt_d = lat_cnt_q + CW'(1);
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // clk_en low freezes every register, which also stretches the access window.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            lat_cnt_q    <= '0;
            word_q       <= '0;
            last_grant_q <= 1'b0;
            mem_addr_q   <= '0;
            mem_we_q     <= 1'b0;
            mem_wdata_q  <= '0;
            inv_q        <= 1'b0;
            inv_addr_q   <= '0;
        end else if (clk_en) begin
            state_q      <= state_d;
            lat_cnt_q    <= lat_cnt_d;
            word_q       <= word_d;
            last_grant_q <= last_grant_d;
            mem_addr_q   <= mem_addr_d;
            mem_we_q     <= mem_we_d;
            mem_wdata_q  <= mem_wdata_d;
            inv_q        <= inv_d;
            inv_addr_q   <= inv_addr_d;
        end
    end

    assign mem_addr              = mem_addr_q;
    assign mem_we                = mem_we_q;
    assign mem_wdata             = mem_wdata_q;
    assign ic_invalidate         = inv_q & clk_en;
    assign ic_invalidate_address = inv_addr_q;

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single external instruction/data memory port between two requesters.
- I-port: instruction-cache line refill, read-only, a burst of LINESIZE words.
- D-port: core load/store, a single-word read or write.
- Sequences fixed-latency memory accesses, alternates grants between the ports when both request, and drives the icache invalidate pair on every accepted D-port write to keep the caches coherent.

Parameters:
DATABITWIDTH, 16, memory word width
ADDRESSWIDTH, 10, word address width
LINESIZE, 8, words per I-port burst (power of 2, >=2); OFFS = $clog2(LINESIZE)
EXT_MEMORY_LATENCY, 1, cycles each word access occupies the memory (>=1)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
clk_en  in  1  global enable; low freezes all state and suppresses all pulses
i_req  in  1  line refill request; held until i_ack
i_addr  in  ADDRESSWIDTH  refill address; low OFFS bits ignored
i_ack  out  1  refill accepted (1-cycle pulse)
i_rvalid  out  1  i_rdata valid (1-cycle pulse per word)
i_rdata  out  DATABITWIDTH  refill word
i_last  out  1  with i_rvalid: final word of the line
d_req  in  1  data request; held until d_ack
d_we  in  1  1 = write, 0 = read
d_addr  in  ADDRESSWIDTH  data address
d_wdata  in  DATABITWIDTH  write data
d_ack  out  1  data request accepted (1-cycle pulse)
d_rvalid  out  1  access complete (read data valid, or write committed)
d_rdata  out  DATABITWIDTH  read data
mem_addr  out  ADDRESSWIDTH  memory address, registered
mem_we  out  1  memory write enable, registered
mem_wdata  out  DATABITWIDTH  memory write data, registered
mem_rdata  in  DATABITWIDTH  memory read data; valid in the last cycle of each access window
ic_invalidate  out  1  icache invalidate pulse
ic_invalidate_address  out  ADDRESSWIDTH  address to invalidate

Behaviour:
- Reset: asynchronous, active-high. Asserting rst forces state IDLE, all counters to 0 and last_grant to D. All outputs go to 0 immediately, including mem_we. An access in flight is abandoned with no rvalid and no ack.
- States:
  - IDLE: the arbiter grants in the cycle T where it sees a request with clk_en high. i_ack/d_ack are combinational in that cycle.
    - Single requester: that requester is granted.
    - Both requesting: the port that is not last_grant is granted. last_grant updates to the winner.
    - On a grant, the address, write data and d_we are captured and the state moves to the granted access state at the edge.
  - I_BURST:
    - Address of word w (w = 0..LINESIZE-1) = {i_addr[ADDRESSWIDTH-1:OFFS], w}.
    - Each word occupies EXT_MEMORY_LATENCY cycles. Word 0's window starts at T+1.
    - In the last cycle of each window, i_rvalid=1 and i_rdata=mem_rdata (combinational pass-through).
    - i_last=1 together with the i_rvalid of word LINESIZE-1. The state then returns to IDLE.
  - D_ACCESS:
    - One window of EXT_MEMORY_LATENCY cycles from T+1. mem_we=d_we is held for the whole window, and mem_wdata is held.
    - In the last cycle of the window: d_rvalid=1, and d_rdata=mem_rdata on reads (d_rdata=0 on writes). The state then returns to IDLE.
- Back-to-back accesses: one IDLE cycle always separates two accesses. The earliest next grant is at the cycle after the final rvalid.
- Requests during an access are neither acked nor lost. A requester holds req, and the request is arbitrated at the next IDLE.
- Dropping req before ack withdraws the request silently.
- mem_addr holds its last value in IDLE. mem_we=0 in IDLE and during I_BURST.
- Invalidate:
  - An accepted D write at T drives ic_invalidate=1 and ic_invalidate_address=d_addr at T+1, for one cycle.
  - D reads never invalidate.
  - ic_invalidate_address holds its value after the pulse.
- clk_en=0: all registers hold. ack/rvalid/invalidate pulses are forced to 0 and reappear when clk_en returns. A window stretches by the number of disabled cycles.
- Latency counter width = max(1, $clog2(EXT_MEMORY_LATENCY)). The counter wraps to 0 at EXT_MEMORY_LATENCY-1.
- The word pointer is OFFS bits wide and wraps to 0 after LINESIZE-1.

Test Plan (LATENCY=2, LINESIZE=4, ADDRESSWIDTH=10, clk_en=1 unless stated):
1. i_req with i_addr=0x1A6 at c0 -> i_ack at c0; mem_addr 0x1A4/0x1A5/0x1A6/0x1A7 for c1-2/c3-4/c5-6/c7-8; i_rvalid at c2, c4, c6, c8; i_last only at c8; IDLE at c9.
2. D write with d_addr=0x055, d_wdata=0xBEEF at c0 -> d_ack at c0; mem_we=1, mem_addr=0x055 and mem_wdata=0xBEEF for c1-2; d_rvalid at c2; ic_invalidate=1 with address 0x055 at c1 only. A D read at the same address produces no invalidate.
3. i_req and d_req both high from c0 after reset -> i_ack at c0 and the burst ends at c8; d_ack at c9. A further simultaneous pair is then granted to I.
4. d_req raised at c3 during the scenario-1 burst -> mem_addr, mem_we and i_rvalid timing unchanged; d_ack at c9; d_rvalid at c11.
5. rst pulsed in c3 of the scenario-1 burst with i_req held -> all outputs 0 immediately; no further i_rvalid; after release, i_ack and a fresh burst from word 0x1A4.
6. D read of 0x010 with clk_en low in c1-c3 and memory returning 0x1234 -> d_rvalid at c5 with d_rdata=0x1234; no pulses while clk_en is low.
